// File: rtl/task4_2_pkg.sv
// Shared constants and types for the task4_2 serial CRC-32 framer.
// Optional feature macro: CRC_INV_EN (all-ones CRC init and final inversion).
package task4_2_pkg;

    localparam logic [31:0] PREAMBLE_DEF = 32'hAA55_AA55;
    localparam logic [31:0] POLY_DEF     = 32'h04C1_1DB7;
    localparam int          NBITS        = 32;

    // Counter value seen on the edge that samples the final payload bit
    localparam logic [4:0]  LAST_BIT     = 5'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

`ifdef CRC_INV_EN
    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT   = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] CRC_INIT     = 32'h0000_0000;
    localparam logic [31:0] CRC_XOROUT   = 32'h0000_0000;
`endif

endpackage

// File: rtl/crc32_serial_step.sv
// One bit-step of an MSB-first, non-reflected CRC-32 LFSR.
// Ports: crc_in (current register), bit_in (next message bit), crc_out (updated register).
module crc32_serial_step
    import task4_2_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic        bit_in,
    output logic [31:0] crc_out
);

    logic fb;

    assign fb      = crc_in[31] ^ bit_in;
    assign crc_out = {crc_in[30:0], 1'b0} ^ (fb ? POLY_DEF : 32'h0);

endmodule

// File: rtl/task4_2.sv
// Serial-in CRC-32 transmitter framer: 32 payload bits after a start strobe
// become {PREAMBLE, payload, crc} on yout, flagged by done.
// Ports: clk, rst_n (async active-low), start, data (serial, MSB first),
//        yout[95:0] (registered frame), done (registered frame-valid).
// Macro CRC_INV_EN selects all-ones CRC init and final inversion.
module task4_2
    import task4_2_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        data,
    output logic [95:0] yout,
    output logic        done
);

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cnt;
    logic [31:0] sr;
    logic [31:0] sr_nx;
    logic [31:0] fec2;
    logic [31:0] fec2_nx;
    logic        last;

    assign sr_nx = {sr[30:0], data};
    assign last  = (cnt == LAST_BIT);

    crc32_serial_step u_step (
        .crc_in  (fec2),
        .bit_in  (data),
        .crc_out (fec2_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last)  state_nx = DONE;
            DONE:    if (start) state_nx = SHIFT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sr   <= '0;
            fec2 <= CRC_INIT;
            yout <= '0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // yout keeps the previous frame until the new one completes
                    if (start) begin
                        cnt  <= '0;
                        fec2 <= CRC_INIT;
                        done <= 1'b0;
                    end
                end
                SHIFT: begin
                    sr   <= sr_nx;
                    fec2 <= fec2_nx;
                    cnt  <= cnt + 5'd1;
                    if (last) begin
                        yout <= {PREAMBLE_DEF, sr_nx, fec2_nx ^ CRC_XOROUT};
                        done <= 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_task4_2.sv
// Self-checking bench for task4_2: directed and random frames against a
// polynomial long-division CRC reference model.
module tb_task4_2;

    localparam logic [31:0] PRE  = 32'hAA55_AA55;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;
`ifdef CRC_INV_EN
    localparam logic [31:0] INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] XOUT = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] INIT = 32'h0;
    localparam logic [31:0] XOUT = 32'h0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        data;
    logic [95:0] yout;
    logic        done;

    int          nvec;
    int          nerr;
    logic [95:0] exp_y;
    logic        exp_done;

    task4_2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .data  (data),
        .yout  (yout),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got,
                         input logic [95:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Remainder of ((msg ^ init) * x^32) mod P, by long division
    function automatic logic [31:0] ref_crc(input logic [31:0] m);
        logic [63:0] r;
        r = {m ^ INIT, 32'h0};
        for (int i = 63; i >= 32; i--)
            if (r[i]) r[i-32 +: 33] = r[i-32 +: 33] ^ {1'b1, POLY};
        return r[31:0] ^ XOUT;
    endfunction

    // glitch: bit index at which start is re-pulsed (-1 none)
    // abort:  bit index at which reset hits mid-frame (-1 none)
    task automatic run_frame(input logic [31:0] p, input int glitch,
                             input int abort);
        @(negedge clk);
        start = 1'b1;
        data  = 1'($urandom);
        @(negedge clk);
        start    = 1'b0;
        exp_done = 1'b0;
        check("start_clears_done", {95'h0, done}, {95'h0, exp_done});
        check("start_keeps_yout", yout, exp_y);
        for (int i = 0; i < 32; i++) begin
            data  = p[31-i];
            start = (i == glitch);
            if (i == abort) begin
                #2 rst_n = 1'b0;
                #1;
                exp_y    = '0;
                exp_done = 1'b0;
                check("abort_yout", yout, exp_y);
                check("abort_done", {95'h0, done}, {95'h0, exp_done});
                @(negedge clk);
                start = 1'b0;
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            if (i < 31) begin
                check("busy_done", {95'h0, done}, 96'h0);
                check("busy_yout", yout, exp_y);
            end
        end
        start    = 1'b0;
        exp_y    = {PRE, p, ref_crc(p)};
        exp_done = 1'b1;
        check("frame_done", {95'h0, done}, {95'h0, exp_done});
        check("frame_yout", yout, exp_y);
        for (int k = 0; k < 3; k++) begin
            data = 1'($urandom);
            @(negedge clk);
            check("hold_done", {95'h0, done}, {95'h0, exp_done});
            check("hold_yout", yout, exp_y);
        end
    endtask

    initial begin
        nvec     = 0;
        nerr     = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        data     = 1'b0;
        exp_y    = '0;
        exp_done = 1'b0;

        #3;
        check("reset_yout", yout, 96'h0);
        check("reset_done", {95'h0, done}, 96'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            data = 1'($urandom);
            @(negedge clk);
            check("idle_yout", yout, 96'h0);
            check("idle_done", {95'h0, done}, 96'h0);
        end

        run_frame(32'h0000_0001, -1, -1);
`ifndef CRC_INV_EN
        check("lit_one", yout, 96'hAA55AA55_00000001_04C11DB7);
`endif
        run_frame(32'h0000_0000, -1, -1);
`ifndef CRC_INV_EN
        check("lit_zero", yout, 96'hAA55AA55_00000000_00000000);
`endif
        run_frame(32'h0301_0203, -1, -1);
        check("pay_0301", {64'h0, yout[63:32]}, 96'h0301_0203);
        run_frame(32'hDEAD_BEEF, 9, -1);
        run_frame(32'h1234_5678, -1, 19);
        run_frame(32'hCAFE_F00D, -1, -1);
        run_frame(32'hFFFF_FFFF, -1, -1);

        for (int n = 0; n < 20; n++) begin
            int g;
            g = (n % 3 == 0) ? int'($urandom_range(30, 0)) : -1;
            if (n % 7 == 3)
                run_frame($urandom, -1, int'($urandom_range(30, 0)));
            else
                run_frame($urandom, g, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
